// File: rtl/snake_body_engine.sv
// Snake segment store and move FSM: each game_tik scans the body for a self-hit, then shifts in the new head.
// A move keeps busy high for length+1 cycles after the tik; the segment read port has 1-cycle latency.
module snake_body_engine #(
  parameter int COORD_BITS  = 7,
  parameter int MAX_LENGTH  = 16,
  parameter int INIT_LENGTH = 3,
  parameter int GRID_W      = 80,
  parameter int GRID_H      = 60,
  parameter int START_X     = 40,
  parameter int START_Y     = 30,
  parameter int WRAP_MODE   = 0,
  parameter int SCORE_BITS  = 7,
  localparam int LEN_BITS   = $clog2(MAX_LENGTH + 1)
) (
  input  logic                  clock_25,
  input  logic                  reset,
  input  logic                  game_tik,
  input  logic                  start,
  input  logic                  right,
  input  logic                  left,
  input  logic                  up,
  input  logic                  down,
  input  logic [COORD_BITS-1:0] fruit_x,
  input  logic [COORD_BITS-1:0] fruit_y,
  input  logic [LEN_BITS-1:0]   rd_index,
  output logic [COORD_BITS-1:0] snake_head_x,
  output logic [COORD_BITS-1:0] snake_head_y,
  output logic [COORD_BITS-1:0] snake_body_x,
  output logic [COORD_BITS-1:0] snake_body_y,
  output logic                  snake_body_valid,
  output logic [LEN_BITS-1:0]   snake_length,
  output logic [SCORE_BITS-1:0] score,
  output logic                  fruit_eaten,
  output logic                  collision_detected,
  output logic                  busy
);
  localparam int IDX_BITS = $clog2(MAX_LENGTH);
  localparam logic [COORD_BITS-1:0] X_LAST   = COORD_BITS'(GRID_W - 1);
  localparam logic [COORD_BITS-1:0] Y_LAST   = COORD_BITS'(GRID_H - 1);
  localparam logic [COORD_BITS-1:0] C_ONE    = COORD_BITS'(1);
  localparam logic [LEN_BITS-1:0]   LEN_INIT = LEN_BITS'(INIT_LENGTH);
  localparam logic [LEN_BITS-1:0]   LEN_MAX  = LEN_BITS'(MAX_LENGTH);
  localparam logic [LEN_BITS-1:0]   LEN_ONE  = LEN_BITS'(1);
  localparam logic [SCORE_BITS-1:0] SCORE_ONE = SCORE_BITS'(1);

  typedef enum logic [2:0] {IDLE, RUN, SCAN, COMMIT, DEAD} state_t;
  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;

  state_t                state;
  dir_t                  dir;
  dir_t                  dir_nxt;
  logic [COORD_BITS-1:0] seg_x [MAX_LENGTH];
  logic [COORD_BITS-1:0] seg_y [MAX_LENGTH];
  logic [COORD_BITS-1:0] new_x, new_y;
  logic [COORD_BITS-1:0] cand_x, cand_y;
  logic [IDX_BITS-1:0]   idx;
  logic                  grow;
  logic                  off_grid;
  logic                  seg_hit;
  logic                  scan_last;

  assign snake_head_x = seg_x[0];
  assign snake_head_y = seg_y[0];
  assign seg_hit      = (seg_x[idx] == new_x) && (seg_y[idx] == new_y);
  assign scan_last    = (LEN_BITS'(idx) == snake_length - LEN_ONE);

  // Highest-priority request wins; if it is a reversal, keep going straight.
  always_comb begin
    dir_nxt = dir;
    if (right) begin
      if (dir != DIR_LEFT) dir_nxt = DIR_RIGHT;
    end else if (left) begin
      if (dir != DIR_RIGHT) dir_nxt = DIR_LEFT;
    end else if (up) begin
      if (dir != DIR_DOWN) dir_nxt = DIR_UP;
    end else if (down) begin
      if (dir != DIR_UP) dir_nxt = DIR_DOWN;
    end
  end

  always_comb begin
    cand_x   = seg_x[0];
    cand_y   = seg_y[0];
    off_grid = 1'b0;
    case (dir)
      DIR_RIGHT:
        if (seg_x[0] == X_LAST) begin
          if (WRAP_MODE != 0) cand_x = '0; else off_grid = 1'b1;
        end else cand_x = seg_x[0] + C_ONE;
      DIR_LEFT:
        if (seg_x[0] == '0) begin
          if (WRAP_MODE != 0) cand_x = X_LAST; else off_grid = 1'b1;
        end else cand_x = seg_x[0] - C_ONE;
      DIR_UP:
        if (seg_y[0] == '0) begin
          if (WRAP_MODE != 0) cand_y = Y_LAST; else off_grid = 1'b1;
        end else cand_y = seg_y[0] - C_ONE;
      DIR_DOWN:
        if (seg_y[0] == Y_LAST) begin
          if (WRAP_MODE != 0) cand_y = '0; else off_grid = 1'b1;
        end else cand_y = seg_y[0] + C_ONE;
    endcase
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      dir                <= DIR_RIGHT;
      snake_length       <= LEN_INIT;
      score              <= '0;
      fruit_eaten        <= 1'b0;
      collision_detected <= 1'b0;
      busy               <= 1'b0;
      snake_body_x       <= '0;
      snake_body_y       <= '0;
      snake_body_valid   <= 1'b0;
      new_x              <= '0;
      new_y              <= '0;
      grow               <= 1'b0;
      idx                <= '0;
      for (int i = 0; i < MAX_LENGTH; i++) begin
        seg_x[i] <= (i < INIT_LENGTH) ? COORD_BITS'(START_X - i) : '0;
        seg_y[i] <= (i < INIT_LENGTH) ? COORD_BITS'(START_Y) : '0;
      end
    end else begin
      fruit_eaten <= 1'b0;

      if (rd_index < snake_length) begin
        snake_body_x     <= seg_x[rd_index[IDX_BITS-1:0]];
        snake_body_y     <= seg_y[rd_index[IDX_BITS-1:0]];
        snake_body_valid <= 1'b1;
      end else begin
        snake_body_x     <= '0;
        snake_body_y     <= '0;
        snake_body_valid <= 1'b0;
      end

      case (state)
        IDLE, DEAD: begin
          if (start) begin
            for (int i = 0; i < MAX_LENGTH; i++) begin
              seg_x[i] <= (i < INIT_LENGTH) ? COORD_BITS'(START_X - i) : '0;
              seg_y[i] <= (i < INIT_LENGTH) ? COORD_BITS'(START_Y) : '0;
            end
            snake_length       <= LEN_INIT;
            dir                <= DIR_RIGHT;
            score              <= '0;
            collision_detected <= 1'b0;
            state              <= RUN;
          end
        end
        RUN: begin
          dir <= dir_nxt;
          if (game_tik) begin
            if (off_grid) begin
              collision_detected <= 1'b1;
              state              <= DEAD;
            end else begin
              new_x <= cand_x;
              new_y <= cand_y;
              grow  <= (cand_x == fruit_x) && (cand_y == fruit_y);
              idx   <= '0;
              busy  <= 1'b1;
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          // The tail vacates its cell this move, so it only blocks when the snake grows.
          if (seg_hit && (!scan_last || grow)) begin
            collision_detected <= 1'b1;
            busy               <= 1'b0;
            state              <= DEAD;
          end else if (scan_last) begin
            state <= COMMIT;
          end else begin
            idx <= idx + IDX_BITS'(1);
          end
        end
        COMMIT: begin
          for (int i = MAX_LENGTH - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= new_x;
          seg_y[0] <= new_y;
          if (grow) begin
            if (snake_length < LEN_MAX) snake_length <= snake_length + LEN_ONE;
            if (score != '1) score <= score + SCORE_ONE;
            fruit_eaten <= 1'b1;
          end
          busy  <= 1'b0;
          state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_engine.sv
// Drives a wall-mode/16-deep engine and a wrap-mode/4-deep engine with shared stimulus
// and compares both against a list-based game model after every move.
module tb_snake_body_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic game_tik = 1'b0, start = 1'b0;
  logic right = 1'b0, left = 1'b0, up = 1'b0, down = 1'b0;
  logic [6:0] fruit_x = '0, fruit_y = '0;
  logic [4:0] rd0 = '0;
  logic [2:0] rd1 = '0;
  logic [6:0] hx0, hy0, bx0, by0, sc0, hx1, hy1, bx1, by1, sc1;
  logic [4:0] len0;
  logic [2:0] len1;
  logic bv0, fe0, co0, bz0, bv1, fe1, co1, bz1;

  always #5 clk = ~clk;

  snake_body_engine u_dut0 (
    .clock_25(clk), .reset(reset), .game_tik(game_tik), .start(start),
    .right(right), .left(left), .up(up), .down(down),
    .fruit_x(fruit_x), .fruit_y(fruit_y), .rd_index(rd0),
    .snake_head_x(hx0), .snake_head_y(hy0), .snake_body_x(bx0), .snake_body_y(by0),
    .snake_body_valid(bv0), .snake_length(len0), .score(sc0), .fruit_eaten(fe0),
    .collision_detected(co0), .busy(bz0));

  snake_body_engine #(.MAX_LENGTH(4), .WRAP_MODE(1)) u_dut1 (
    .clock_25(clk), .reset(reset), .game_tik(game_tik), .start(start),
    .right(right), .left(left), .up(up), .down(down),
    .fruit_x(fruit_x), .fruit_y(fruit_y), .rd_index(rd1),
    .snake_head_x(hx1), .snake_head_y(hy1), .snake_body_x(bx1), .snake_body_y(by1),
    .snake_body_valid(bv1), .snake_length(len1), .score(sc1), .fruit_eaten(fe1),
    .collision_detected(co1), .busy(bz1));

  int o_hx[2], o_hy[2], o_len[2], o_sc[2], o_co[2], o_bz[2], o_bx[2], o_by[2], o_bv[2];
  always_comb begin
    o_hx[0] = int'(hx0);  o_hy[0] = int'(hy0);  o_len[0] = int'(len0); o_sc[0] = int'(sc0);
    o_co[0] = int'(co0);  o_bz[0] = int'(bz0);  o_bx[0] = int'(bx0);   o_by[0] = int'(by0);
    o_bv[0] = int'(bv0);
    o_hx[1] = int'(hx1);  o_hy[1] = int'(hy1);  o_len[1] = int'(len1); o_sc[1] = int'(sc1);
    o_co[1] = int'(co1);  o_bz[1] = int'(bz1);  o_bx[1] = int'(bx1);   o_by[1] = int'(by1);
    o_bv[1] = int'(bv1);
  end

  int fe_cnt0 = 0, fe_cnt1 = 0;
  always @(posedge clk) begin
    if (fe0) fe_cnt0 <= fe_cnt0 + 1;
    if (fe1) fe_cnt1 <= fe_cnt1 + 1;
  end

  int cmp_n = 0, bad_n = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    cmp_n++;
    if (obs != exp) begin
      bad_n++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Game model: segment list per engine, state 0=idle 1=running 2=dead, dir 0=R 1=L 2=U 3=D.
  int mx[2][16], my[2][16];
  int mlen[2], mdir[2], msc[2], mst[2];

  function automatic int max_len(int k);
    return (k == 0) ? 16 : 4;
  endfunction

  task automatic model_init(input int k, input int st);
    for (int i = 0; i < 16; i++) begin
      mx[k][i] = (i < 3) ? 40 - i : 0;
      my[k][i] = (i < 3) ? 30 : 0;
    end
    mlen[k] = 3; mdir[k] = 0; msc[k] = 0; mst[k] = st;
  endtask

  function automatic int pick_dir(int d, bit r, bit l, bit u, bit dn);
    int p = d;
    if (r) p = 0; else if (l) p = 1; else if (u) p = 2; else if (dn) p = 3;
    return (p == (d ^ 1)) ? d : p;
  endfunction

  task automatic next_head(input int k, input int d, output int nx, output int ny, output bit off);
    nx = mx[k][0]; ny = my[k][0];
    case (d)
      0: nx = nx + 1;
      1: nx = nx - 1;
      2: ny = ny - 1;
      default: ny = ny + 1;
    endcase
    off = 1'b0;
    if (k == 1) begin
      nx = (nx + 80) % 80; ny = (ny + 60) % 60;
    end else off = (nx < 0 || nx > 79 || ny < 0 || ny > 59);
  endtask

  // kind: 0 moved, 1 wall death, 2 self-hit at index hit, 3 not running.
  task automatic model_step(input int k, input bit r, input bit l, input bit u, input bit dn,
                            input int fx, input int fy,
                            output int kind, output int hit, output int ln, output int grw);
    int nx, ny, nl;
    bit off;
    kind = 3; hit = -1; ln = mlen[k]; grw = 0;
    if (mst[k] != 1) return;
    mdir[k] = pick_dir(mdir[k], r, l, u, dn);
    next_head(k, mdir[k], nx, ny, off);
    if (off) begin mst[k] = 2; kind = 1; return; end
    grw = int'(nx == fx && ny == fy);
    for (int i = 0; i < ln; i++)
      if ((i < ln - 1 || grw != 0) && hit < 0 && mx[k][i] == nx && my[k][i] == ny) hit = i;
    if (hit >= 0) begin mst[k] = 2; kind = 2; return; end
    kind = 0;
    nl = (grw != 0 && ln < max_len(k)) ? ln + 1 : ln;
    for (int i = nl - 1; i > 0; i--) begin
      mx[k][i] = mx[k][i-1]; my[k][i] = my[k][i-1];
    end
    mx[k][0] = nx; my[k][0] = ny; mlen[k] = nl;
    if (grw != 0 && msc[k] < 127) msc[k]++;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("d%0d head_x", k), o_hx[k], mx[k][0]);
      check_val($sformatf("d%0d head_y", k), o_hy[k], my[k][0]);
      check_val($sformatf("d%0d length", k), o_len[k], mlen[k]);
      check_val($sformatf("d%0d score", k), o_sc[k], msc[k]);
      check_val($sformatf("d%0d collision", k), o_co[k], int'(mst[k] == 2));
      check_val($sformatf("d%0d busy_idle", k), o_bz[k], 0);
    end
    for (int r = 0; r < 17; r++) begin
      @(negedge clk);
      rd0 = 5'(r);
      rd1 = 3'((r < 8) ? r : 7);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (k == 0 || r < 8) begin
          check_val($sformatf("d%0d valid[%0d]", k, r), o_bv[k], int'(r < mlen[k]));
          if (r < mlen[k]) begin
            check_val($sformatf("d%0d body_x[%0d]", k, r), o_bx[k], mx[k][r]);
            check_val($sformatf("d%0d body_y[%0d]", k, r), o_by[k], my[k][r]);
          end else if (r >= max_len(k)) begin
            check_val($sformatf("d%0d body_oor[%0d]", k, r), o_bx[k] + o_by[k], 0);
          end
        end
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    right = 1'b0; left = 1'b0; up = 1'b0; down = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) if (mst[k] != 1) model_init(k, 1);
  endtask

  task automatic do_tik(input bit r, input bit l, input bit u, input bit dn, input int fx, input int fy);
    int kind[2], hit[2], ln[2], grw[2], oldx[2], oldy[2], fe_before[2];
    int exp_low[2], exp_coll[2], low[2], coll_at[2], bhx[2], bhy[2];
    @(negedge clk);
    right = r; left = l; up = u; down = dn;
    fruit_x = 7'(fx); fruit_y = 7'(fy);
    @(negedge clk);
    @(negedge clk);
    fe_before[0] = fe_cnt0; fe_before[1] = fe_cnt1;
    for (int k = 0; k < 2; k++) begin
      oldx[k] = mx[k][0]; oldy[k] = my[k][0];
      model_step(k, r, l, u, dn, fx, fy, kind[k], hit[k], ln[k], grw[k]);
      case (kind[k])
        0: begin exp_low[k] = ln[k] + 1; exp_coll[k] = -1; end
        1: begin exp_low[k] = 0; exp_coll[k] = 0; end
        2: begin exp_low[k] = 1 + hit[k]; exp_coll[k] = 1 + hit[k]; end
        default: begin exp_low[k] = 0; exp_coll[k] = (mst[k] == 2) ? 0 : -1; end
      endcase
      low[k] = -1; coll_at[k] = -1; bhx[k] = oldx[k]; bhy[k] = oldy[k];
    end
    game_tik = 1'b1;
    @(negedge clk);
    game_tik = 1'b0;
    for (int c = 0; c < 28; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (low[k] < 0) begin
          if (o_bz[k] == 0) low[k] = c;
          else begin bhx[k] = o_hx[k]; bhy[k] = o_hy[k]; end
        end
        if (coll_at[k] < 0 && o_co[k] != 0) coll_at[k] = c;
      end
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("d%0d busy_cycles", k), low[k], exp_low[k]);
      check_val($sformatf("d%0d collision_cycle", k), coll_at[k], exp_coll[k]);
      check_val($sformatf("d%0d fruit_pulses", k),
                ((k == 0) ? fe_cnt0 : fe_cnt1) - fe_before[k], int'(kind[k] == 0 && grw[k] != 0));
      if (kind[k] == 0 || kind[k] == 2)
        check_val($sformatf("d%0d head_held_busy", k), bhx[k] * 64 + bhy[k], oldx[k] * 64 + oldy[k]);
    end
    compare_all();
  endtask

  initial begin
    int q, t, fx, fy, nx, ny;
    bit off, rq, lq, uq, dq;
    model_init(0, 0);
    model_init(1, 0);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("d%0d rst_head_x", k), o_hx[k], 40);
      check_val($sformatf("d%0d rst_length", k), o_len[k], 3);
      check_val($sformatf("d%0d rst_score", k), o_sc[k], 0);
      check_val($sformatf("d%0d rst_coll", k), o_co[k], 0);
      check_val($sformatf("d%0d rst_busy", k), o_bz[k], 0);
      check_val($sformatf("d%0d rst_valid", k), o_bv[k], 0);
    end
    @(negedge clk);
    reset = 1'b0;
    compare_all();

    do_start();
    do_tik(1, 0, 0, 0, 5, 5);      // plain move right
    do_tik(1, 0, 0, 0, 42, 30);    // eat
    do_tik(0, 1, 0, 0, 5, 5);      // reversal ignored
    do_tik(0, 0, 1, 1, 5, 5);      // up beats down
    for (int n = 0; n < 45 && mst[0] != 2; n++) do_tik(1, 0, 0, 0, 5, 5);
    check_val("d0 wall_dead", o_co[0], 1);
    check_val("d0 wall_head_x", o_hx[0], 79);

    do_start();
    do_tik(1, 0, 0, 0, 41, 30);
    do_tik(1, 0, 0, 0, 42, 30);
    do_tik(0, 0, 0, 1, 5, 5);
    do_tik(0, 1, 0, 0, 5, 5);
    do_tik(0, 0, 1, 0, 5, 5);
    check_val("d0 self_dead", o_co[0], 1);
    do_start();
    compare_all();

    for (int n = 0; n < 150; n++) begin
      if ((mst[0] == 2 && mst[1] == 2) || ((mst[0] == 2 || mst[1] == 2) && $urandom_range(0, 5) == 0))
        do_start();
      q = $urandom_range(0, 4);
      rq = (q == 0); lq = (q == 1); uq = (q == 2); dq = (q == 3);
      t = $urandom_range(0, 2);
      fx = $urandom_range(0, 79); fy = $urandom_range(0, 59);
      if (t < 2 && mst[t] == 1) begin
        next_head(t, pick_dir(mdir[t], rq, lq, uq, dq), nx, ny, off);
        if (!off) begin fx = nx; fy = ny; end
      end
      do_tik(rq, lq, uq, dq, fx, fy);
    end

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_init(0, 0);
    model_init(1, 0);
    do_start();
    @(negedge clk);
    right = 1'b1;
    @(negedge clk);
    game_tik = 1'b1;
    @(negedge clk);
    game_tik = 1'b0;
    @(negedge clk);
    check_val("d0 busy_in_scan", o_bz[0], 1);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("d%0d mid_rst_busy", k), o_bz[k], 0);
      check_val($sformatf("d%0d mid_rst_len", k), o_len[k], 3);
      check_val($sformatf("d%0d mid_rst_coll", k), o_co[k], 0);
      check_val($sformatf("d%0d mid_rst_head_x", k), o_hx[k], 40);
    end
    @(negedge clk);
    reset = 1'b0;
    model_init(0, 0);
    model_init(1, 0);
    do_start();
    do_tik(1, 0, 0, 0, 5, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end
endmodule
